vga_timing_gen: RTL

//  Parametrised, clock-enabled raster timing generator: any resolution, selectable sync polarity, start/stop control.

---
 rtl/vga_pkg.sv | 43 ++++
 rtl/vga_axis_counter.sv | 61 ++++++
 rtl/vga_timing_gen.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types, timing descriptors and standard mode constants for the raster generator.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // One axis of raster timing: active, front porch, sync, back porch.
  typedef struct packed {
    int unsigned a;
    int unsigned fp;
    int unsigned s;
    int unsigned bp;
  } timing_t;

  typedef struct packed {
    timing_t h;
    timing_t v;
  } mode_t;

  // Total period of one axis.
  function automatic int unsigned tot(input timing_t t);
    return t.a + t.fp + t.s + t.bp;
  endfunction

  // Every interval of an axis must be at least one unit long.
  function automatic bit timing_ok(input timing_t t);
    return (t.a >= 1) && (t.fp >= 1) && (t.s >= 1) && (t.bp >= 1);
  endfunction

  localparam mode_t VGA_1024x768 = '{
    h: '{a: 1024, fp: 24, s: 136, bp: 160},
    v: '{a: 768,  fp: 3,  s: 6,   bp: 29}
  };

  localparam mode_t VGA_640x480 = '{
    h: '{a: 640, fp: 16, s: 96, bp: 48},
    v: '{a: 480, fp: 10, s: 2,  bp: 33}
  };

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with registered active/sync decodes.
// The decodes are taken from the next count so they line up with the counter register.
module vga_axis_counter #(
  parameter int unsigned A   = 8,
  parameter int unsigned FP  = 1,
  parameter int unsigned S   = 1,
  parameter int unsigned BP  = 1,
  parameter bit          POL = 1'b0,
  parameter int unsigned W   = $clog2(A + FP + S + BP)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         active,
  output logic         sync
);

  localparam logic [W-1:0] LAST     = W'(A + FP + S + BP - 1);
  localparam logic [W-1:0] ACT_END  = W'(A);
  localparam logic [W-1:0] SYNC_BEG = W'(A + FP);
  localparam logic [W-1:0] SYNC_END = W'(A + FP + S);

  logic [W-1:0] cnt_q, cnt_d;
  logic         active_q;
  logic         sync_q;

  assign wrap = inc & (cnt_q == LAST);

  // Next position: hold, step, or wrap at the end of the period.
  always_comb begin
    cnt_d = cnt_q;
    if (inc) begin
      cnt_d = wrap ? '0 : cnt_q + W'(1);
    end
  end

  // Position and decoded flags; clr forces the idle (deasserted) levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      sync_q   <= ~POL;
    end else if (clr) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      sync_q   <= ~POL;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= (cnt_d < ACT_END);
      sync_q   <= ((cnt_d >= SYNC_BEG) && (cnt_d < SYNC_END)) ? POL : ~POL;
    end
  end

  assign cnt    = cnt_q;
  assign active = active_q;
  assign sync   = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Clock-enabled raster timing generator with start/drain control, line/frame
// strobes and a completed-frame counter.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_A   = 1024,
  parameter int unsigned H_FP  = 24,
  parameter int unsigned H_S   = 136,
  parameter int unsigned H_BP  = 160,
  parameter int unsigned V_A   = 768,
  parameter int unsigned V_FP  = 3,
  parameter int unsigned V_S   = 6,
  parameter int unsigned V_BP  = 29,
  parameter bit          H_POL = 1'b0,
  parameter bit          V_POL = 1'b0,
  parameter int unsigned X_W   = 11,
  parameter int unsigned Y_W   = 10,
  parameter int unsigned FC_W  = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pix_en,
  input  logic            en,
  output logic            hsync,
  output logic            vsync,
  output logic            active_video,
  output logic [X_W-1:0]  pixel_x,
  output logic [Y_W-1:0]  pixel_y,
  output logic            line_start,
  output logic            frame_start,
  output logic            busy,
  output logic [FC_W-1:0] frame_cnt
);

  localparam timing_t     HT    = '{a: H_A, fp: H_FP, s: H_S, bp: H_BP};
  localparam timing_t     VT    = '{a: V_A, fp: V_FP, s: V_S, bp: V_BP};
  localparam int unsigned H_TOT = tot(HT);
  localparam int unsigned V_TOT = tot(VT);
  localparam int unsigned HW    = $clog2(H_TOT);
  localparam int unsigned VW    = $clog2(V_TOT);

  if (!timing_ok(HT) || !timing_ok(VT)) begin : g_bad_timing
    $error("vga_timing_gen: every active/porch/sync interval must be >= 1");
  end
  if ((X_W < $clog2(H_A)) || (Y_W < $clog2(V_A))) begin : g_bad_width
    $error("vga_timing_gen: X_W/Y_W too narrow for the active region");
  end

  state_t          state_q;
  logic            busy_q;
  logic            line_start_q;
  logic            frame_start_q;
  logic [FC_W-1:0] frame_cnt_q;

  logic [HW-1:0]   h_cnt;
  logic [VW-1:0]   v_cnt;
  logic            h_wrap, v_wrap;
  logic            h_active, v_active;
  logic            h_sync, v_sync;

  logic            running;
  logic            start;
  logic            stop;
  logic            clr;
  logic            h_inc;

  // Control decode: start presents (0,0) without stepping; the final tick of a
  // frame with en low clears both axes straight back to idle levels.
  always_comb begin
    running = (state_q != IDLE);
    start   = (state_q == IDLE) & pix_en & en;
    stop    = v_wrap & ~en;
    clr     = (~running & ~start) | stop;
    h_inc   = pix_en & running;
  end

  vga_axis_counter #(
    .A  (H_A),
    .FP (H_FP),
    .S  (H_S),
    .BP (H_BP),
    .POL(H_POL),
    .W  (HW)
  ) u_h (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (h_inc),
    .cnt   (h_cnt),
    .wrap  (h_wrap),
    .active(h_active),
    .sync  (h_sync)
  );

  vga_axis_counter #(
    .A  (V_A),
    .FP (V_FP),
    .S  (V_S),
    .BP (V_BP),
    .POL(V_POL),
    .W  (VW)
  ) u_v (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (h_wrap),
    .cnt   (v_cnt),
    .wrap  (v_wrap),
    .active(v_active),
    .sync  (v_sync)
  );

  // Run-control FSM with registered busy, strobes and completed-frame count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      busy_q        <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else if (pix_en) begin
      case (state_q)
        IDLE: begin
          busy_q        <= en;
          line_start_q  <= en;
          frame_start_q <= en;
          if (en) begin
            state_q <= RUN;
          end
        end
        RUN, DRAIN: begin
          if (v_wrap) begin
            frame_cnt_q <= frame_cnt_q + FC_W'(1);
          end
          if (stop) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
          end else begin
            state_q       <= en ? RUN : DRAIN;
            busy_q        <= 1'b1;
            line_start_q  <= h_wrap;
            frame_start_q <= v_wrap;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Active region and coordinates are gated directly from the axis registers.
  assign active_video = h_active & v_active;
  assign pixel_x      = active_video ? X_W'(h_cnt) : '0;
  assign pixel_y      = active_video ? Y_W'(v_cnt) : '0;
  assign hsync        = h_sync;
  assign vsync        = v_sync;
  assign line_start   = line_start_q;
  assign frame_start  = frame_start_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
